// File: rtl/button_event_queue_pkg.sv
// Event byte layout shared by the button event queue and the I2C register map.
// An event byte is {seq, idx}: the push sequence number above the button index.
package button_event_queue_pkg;

   localparam int EVT_W = 8;
   localparam int SEQ_W = 4;
   localparam int IDX_W = 4;
   localparam int IDX_LSB = 0;
   localparam int SEQ_LSB = IDX_W;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [IDX_W-1:0] idx;
   } evt_t;

   function automatic evt_t make_evt(input logic [SEQ_W-1:0] seq,
                                     input logic [IDX_W-1:0] idx);
      evt_t e;
      e.seq = seq;
      e.idx = idx;
      return e;
   endfunction

endpackage

// File: rtl/button_event_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO with separately tracked occupancy.
// The head reads as zero while empty; push and pop in one cycle are legal when full.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; emptiness is decided by count alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/button_event_queue.sv
// Collects debounced press strobes into a pending set, serialises them lowest
// index first and queues them as {seq, idx} event bytes for a valid/ack reader.
module button_event_queue
   import button_event_queue_pkg::*;
#(
   parameter int NUM_BTN    = 4,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_BTN-1:0]    btn_e,
   output logic                  evt_valid,
   output logic [EVT_W-1:0]      evt_data,
   input  logic                  evt_ack,
   output logic [DEPTH_LOG2:0]   evt_count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] push_mask;
   logic [IDX_W-1:0]   push_idx;
   logic               any_pending;
   logic               push_en;
   logic               pop_en;
   logic               loss;
   logic               full;
   logic               empty;
   logic [SEQ_W-1:0]   seq;
   evt_t               head_evt;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      any_pending = 1'b0;
      push_idx    = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pending[i]) begin
            any_pending = 1'b1;
            push_idx    = IDX_W'(i);
         end
      end
   end

   assign pop_en    = evt_ack & ~empty;
   assign push_en   = any_pending & (~full | pop_en);
   assign push_mask = push_en ? (NUM_BTN'(1) << push_idx) : '0;
   // A strobe on a bit that is being pushed this cycle simply re-arms it.
   assign loss      = |(btn_e & pending & ~push_mask);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= '0;
         seq      <= '0;
         overflow <= 1'b0;
      end else begin
         pending <= (pending & ~push_mask) | btn_e;
         if (push_en) seq <= seq + 1'b1;
         if (loss)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH      (EVT_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en),
      .push_data (make_evt(seq, push_idx)),
      .pop       (pop_en),
      .head      (head_evt),
      .full      (full),
      .empty     (empty),
      .count     (evt_count)
   );

   assign evt_valid = ~empty;
   assign evt_data  = head_evt;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: latency, serialisation, full/overflow,
// sequence wrap and reset behaviour with hand-computed expected event bytes.
module tb_button_event_queue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_e;
   logic       evt_valid;
   logic [7:0] evt_data;
   logic       evt_ack;
   logic [3:0] evt_count;
   logic       overflow;
   logic       ovf_clr;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   button_event_queue #(.NUM_BTN(4), .DEPTH_LOG2(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_e     (btn_e),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .evt_ack   (evt_ack),
      .evt_count (evt_count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      btn_e   = '0;
      evt_ack = 1'b0;
      ovf_clr = 1'b0;
      rst_n   = 1'b0;
      tick(2);
      rst_n   = 1'b1;
   endtask

   // One isolated strobe, then the cycle in which it gets pushed (if there is room).
   task automatic press(input logic [3:0] b);
      btn_e = b;
      tick();
      btn_e = '0;
      tick();
   endtask

   initial begin
      do_reset();
      check("rst_valid", evt_valid, 0);
      check("rst_data", evt_data, 8'h00);
      check("rst_count", evt_count, 0);
      check("rst_ovf", overflow, 0);

      // 1: strobe-to-valid latency and pop.
      btn_e = 4'b0100;
      tick();
      btn_e = '0;
      check("t1_not_yet", evt_valid, 0);
      tick();
      check("t1_valid", evt_valid, 1);
      check("t1_data", evt_data, 8'h02);
      check("t1_count", evt_count, 1);
      evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      check("t1_pop_valid", evt_valid, 0);
      check("t1_pop_count", evt_count, 0);
      check("t1_empty_data", evt_data, 8'h00);

      // 2: simultaneous strobes serialise lowest index first.
      do_reset();
      btn_e = 4'b1011;
      tick();
      btn_e = '0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t2_count", evt_count, i);
         check("t2_head", evt_data, 8'h00);
      end
      tick();
      check("t2_count_hold", evt_count, 3);
      begin
         logic [7:0] exp2 [3] = '{8'h00, 8'h11, 8'h23};
         evt_ack = 1'b1;
         for (int i = 0; i < 3; i++) begin
            check("t2_pop_data", evt_data, exp2[i]);
            tick();
         end
         evt_ack = 1'b0;
      end
      check("t2_drained", evt_valid, 0);

      // 3: fill to 8, ninth press waits, ack lets it in with count unchanged.
      do_reset();
      for (int i = 0; i < 8; i++) press(4'b0001);
      check("t3_full_count", evt_count, 8);
      press(4'b0001);
      check("t3_held_count", evt_count, 8);
      check("t3_no_ovf", overflow, 0);
      check("t3_head", evt_data, 8'h00);
      evt_ack = 1'b1;
      tick();
      evt_ack = 1'b0;
      check("t3_pushpop_count", evt_count, 8);
      check("t3_new_head", evt_data, 8'h10);

      // 4: loss while full, set beats clear, then clear alone.
      press(4'b0001);
      check("t4_pending_no_ovf", overflow, 0);
      btn_e = 4'b0001;
      tick();
      btn_e = '0;
      check("t4_ovf_set", overflow, 1);
      btn_e   = 4'b0001;
      ovf_clr = 1'b1;
      tick();
      btn_e = '0;
      check("t4_set_wins", overflow, 1);
      tick();
      ovf_clr = 1'b0;
      check("t4_cleared", overflow, 0);
      check("t4_count", evt_count, 8);
      evt_ack = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         logic [7:0] exp4;
         exp4 = {4'(i), 4'h0};
         check("t4_drain_data", evt_data, exp4);
         tick();
      end
      evt_ack = 1'b0;
      check("t4_drained_valid", evt_valid, 0);
      check("t4_drained_count", evt_count, 0);
      check("t4_drained_data", evt_data, 8'h00);

      // 5: sequence number wraps after 16 pushes.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         logic [7:0] exp5;
         exp5 = {4'(i), 4'h3};
         press(4'b1000);
         check("t5_seq_data", evt_data, exp5);
         evt_ack = 1'b1;
         tick();
         evt_ack = 1'b0;
      end
      check("t5_empty", evt_valid, 0);

      // 6: reset with queued entries and pending bits discards everything.
      do_reset();
      press(4'b1111);
      tick(3);
      press(4'b0001);
      check("t6_count", evt_count, 5);
      btn_e = 4'b0110;
      tick();
      btn_e = '0;
      rst_n = 1'b0;
      ovf_clr = 1'b0;
      tick();
      check("t6_rst_valid", evt_valid, 0);
      check("t6_rst_data", evt_data, 8'h00);
      check("t6_rst_count", evt_count, 0);
      check("t6_rst_ovf", overflow, 0);
      rst_n = 1'b1;
      tick(2);
      check("t6_no_pending", evt_valid, 0);
      press(4'b0100);
      check("t6_after_valid", evt_valid, 1);
      check("t6_after_data", evt_data, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
